// File: rtl/lma0_pkg.sv
// Shared types and opcode constants for the LMA0 control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lma0_pkg;

  // Sequencer states; encodings are visible on the debug state port.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  // Opcode fields, matched against instr[15:12] (4-bit) or instr[15:13] (3-bit).
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ITYPE = 4'b0001;
  localparam logic [2:0] OP_ILL   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_JEQ   = 3'b100;
  localparam logic [2:0] OP_JLT   = 3'b101;
  localparam logic [2:0] OP_JAL   = 3'b110;
  localparam logic [2:0] OP_JR    = 3'b111;
  // LCG lives inside the R-type opcode space, matched on instr[15:9].
  localparam logic [6:0] OP_LCG   = 7'b0000100;

  // Return-address register written by JAL.
  localparam logic [2:0] RA_IDX   = 3'd7;

  // Instruction class, exactly one bit set for any instr value.
  typedef struct packed {
    logic rtype;
    logic lcg;
    logic itype;
    logic ill;
    logic load;
    logic store;
    logic jeq;
    logic jlt;
    logic jal;
    logic jr;
  } iclass_t;

endpackage

// File: rtl/lma0_idecode.sv
// Combinational instruction-class decoder (one-hot), shared with datapath muxes.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: instr (IR contents) -> cls (one-hot iclass_t).
module lma0_idecode
  import lma0_pkg::*;
(
  input  logic [15:0] instr,
  output iclass_t     cls
);

  logic [3:0] op4;
  logic [2:0] op3;
  logic       is_lcg;
  logic       unused_operands;

  assign op4    = instr[15:12];
  assign op3    = instr[15:13];
  assign is_lcg = (instr[15:9] == OP_LCG);
  // Operand fields are consumed by the datapath, not by class decode.
  assign unused_operands = ^instr[8:0];

  always_comb begin
    cls       = '0;
    cls.lcg   = is_lcg;
    cls.rtype = (op4 == OP_RTYPE) && !is_lcg;
    cls.itype = (op4 == OP_ITYPE);
    cls.ill   = (op3 == OP_ILL);
    cls.load  = (op3 == OP_LOAD);
    cls.store = (op3 == OP_STORE);
    cls.jeq   = (op3 == OP_JEQ);
    cls.jlt   = (op3 == OP_JLT);
    cls.jal   = (op3 == OP_JAL);
    cls.jr    = (op3 == OP_JR);
  end

endmodule

// File: rtl/lma0_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the LMA0 16-bit core.
// Latency: R/I 4, LCG 3+LCG_CYCLES, load 5, store 4, jumps 3 cycles (zero-wait memory).
// Backpressure: FETCH and MEM hold mem_req with stable outputs until mem_ack.
// Ports: run/instr/mem_ack/flag_z/flag_n in; memory, PC, IR, regfile and ALU
// strobes plus insn_done/illegal pulses and debug state out.
module lma0_ctrl
  import lma0_pkg::*;
#(
  parameter int LCG_CYCLES = 4,
  parameter int STATE_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [15:0]        instr,
  input  logic               mem_ack,
  input  logic               flag_z,
  input  logic               flag_n,
  output logic               mem_req,
  output logic               mem_we,
  output logic               addr_sel,
  output logic               ir_en,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               pc_src,
  output logic               reg_we,
  output logic               alu_go,
  output logic               insn_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = (LCG_CYCLES > 1) ? $clog2(LCG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LCG_LAST = CNT_W'(LCG_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_t          cls;
  state_e           retire_st;
  logic             exec_first;

  lma0_idecode u_idecode (
    .instr (instr),
    .cls   (cls)
  );

  // run is only consulted at the retire boundary, so dropping it never aborts.
  assign retire_st = run ? S_FETCH : S_IDLE;
  // Non-LCG classes spend one EXEC cycle; LCG's first cycle is when the
  // counter still holds its load value.
  assign exec_first = !cls.lcg || (cnt_q == LCG_LAST);
  assign state = STATE_W'(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_en     = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    pc_src    = 1'b0;
    reg_we    = 1'b0;
    alu_go    = 1'b0;
    insn_done = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_en   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // IR is valid here, so the LCG counter is primed before EXEC entry.
        cnt_d   = cls.lcg ? LCG_LAST : '0;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (cls.ill) begin
          illegal   = 1'b1;
          insn_done = 1'b1;
          state_d   = retire_st;
        end else begin
          alu_go = exec_first;
          if (cls.rtype || cls.itype) begin
            state_d = S_WB;
          end else if (cls.lcg) begin
            if (cnt_q == '0) state_d = S_WB;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end else if (cls.load || cls.store) begin
            state_d = S_MEM;
          end else if (cls.jeq || cls.jlt) begin
            pc_load   = cls.jeq ? flag_z : flag_n;
            insn_done = 1'b1;
            state_d   = retire_st;
          end else if (cls.jal) begin
            // Datapath routes incremented PC to din and RA_IDX to r0addr.
            reg_we    = 1'b1;
            pc_load   = 1'b1;
            insn_done = 1'b1;
            state_d   = retire_st;
          end else begin
            pc_load   = 1'b1;
            pc_src    = 1'b1;
            insn_done = 1'b1;
            state_d   = retire_st;
          end
        end
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = cls.store;
        if (mem_ack) begin
          if (cls.load) begin
            state_d = S_WB;
          end else begin
            insn_done = 1'b1;
            state_d   = retire_st;
          end
        end
      end

      S_WB: begin
        reg_we    = 1'b1;
        insn_done = 1'b1;
        state_d   = retire_st;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lma0_ctrl.sv
module tb_lma0_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        flag_z = 1'b0;
  logic        flag_n = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_en, pc_inc, pc_load, pc_src;
  logic        reg_we, alu_go, insn_done, illegal;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  // Observed vector: {state[2:0], mem_req, mem_we, addr_sel, ir_en, pc_inc,
  //                   pc_load, pc_src, reg_we, alu_go, insn_done, illegal}
  localparam logic [10:0] REQ   = 11'h400;
  localparam logic [10:0] WE    = 11'h200;
  localparam logic [10:0] ASEL  = 11'h100;
  localparam logic [10:0] IREN  = 11'h080;
  localparam logic [10:0] PCINC = 11'h040;
  localparam logic [10:0] PCLD  = 11'h020;
  localparam logic [10:0] PCSRC = 11'h010;
  localparam logic [10:0] REGWE = 11'h008;
  localparam logic [10:0] ALU   = 11'h004;
  localparam logic [10:0] DONE  = 11'h002;
  localparam logic [10:0] ILL   = 11'h001;
  localparam logic [10:0] NONE  = 11'h000;
  localparam logic [10:0] F1    = REQ | IREN | PCINC;
  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SW = 3'd5;

  lma0_ctrl #(.LCG_CYCLES(4), .STATE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_ack(mem_ack),
    .flag_z(flag_z), .flag_n(flag_n), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_en(ir_en), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_src(pc_src), .reg_we(reg_we), .alu_go(alu_go), .insn_done(insn_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pk();
    return {state, mem_req, mem_we, addr_sel, ir_en, pc_inc, pc_load, pc_src,
            reg_we, alu_go, insn_done, illegal};
  endfunction

  // Reset, then release with run=1; returns at the negedge of the first FETCH cycle.
  task automatic start(input logic [15:0] ins);
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
    instr = ins;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [13:0] exp [4];
    logic        ack [4];
    rst_n = 1'b0;
    #1;
    checks++;
    if (pk() !== 14'h0) begin
      $display("FAIL reset_init got=%h exp=%h", pk(), 14'h0); failures++;
    end
    start(16'h4001);
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU}, {SM, REQ | ASEL}};
    ack = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      mem_ack = ack[i];
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL reset_pre cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
    // Still waiting in MEM; assert reset between clock edges.
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pk() !== 14'h0) begin
      $display("FAIL reset_mid_mem got=%h exp=%h", pk(), 14'h0); failures++;
    end
    rst_n = 1'b1; run = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (pk() !== {SF, REQ}) begin
      $display("FAIL reset_refetch got=%h exp=%h", pk(), {SF, REQ}); failures++;
    end
  endtask

  task automatic test_rtype();
    logic [13:0] exp [5];
    start(16'h0123);
    mem_ack = 1'b1;
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU}, {SW, REGWE | DONE}, {SF, F1}};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL rtype cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_itype();
    logic [13:0] exp [4];
    start(16'h1234);
    mem_ack = 1'b1;
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU}, {SW, REGWE | DONE}};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL itype cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lcg();
    logic [13:0] exp [8];
    start(16'h0800);
    mem_ack = 1'b1;
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU}, {SE, NONE}, {SE, NONE}, {SE, NONE},
            {SW, REGWE | DONE}, {SF, F1}};
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL lcg cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic [13:0] exp [8];
    logic        ack [8];
    start(16'h4001);
    // ack in DECODE/EXEC must be ignored.
    ack = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU}, {SM, REQ | ASEL}, {SM, REQ | ASEL},
            {SM, REQ | ASEL}, {SW, REGWE | DONE}, {SF, REQ}};
    for (int i = 0; i < 8; i++) begin
      mem_ack = ack[i];
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL load_wait cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [13:0] exp [5];
    start(16'h6001);
    mem_ack = 1'b1;
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU}, {SM, REQ | WE | ASEL | DONE}, {SF, F1}};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL store cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jeq_jlt();
    logic [13:0] exp [10];
    logic        fz [10];
    logic        fn [10];
    logic [15:0] ins [10];
    start(16'h8000);
    mem_ack = 1'b1;
    // JEQ taken, JEQ not taken (flag_n set but irrelevant), JLT taken.
    ins = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
            16'hA000, 16'hA000, 16'hA000, 16'hA000};
    fz  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    fn  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU | PCLD | DONE},
            {SF, F1}, {SD, NONE}, {SE, ALU | DONE},
            {SF, F1}, {SD, NONE}, {SE, ALU | PCLD | DONE}, {SF, F1}};
    for (int i = 0; i < 10; i++) begin
      instr = ins[i]; flag_z = fz[i]; flag_n = fn[i];
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL jeq_jlt cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jal_jr();
    logic [13:0] exp [7];
    logic [15:0] ins [7];
    start(16'hC005);
    mem_ack = 1'b1;
    ins = '{16'hC005, 16'hC005, 16'hC005, 16'hC005, 16'hE000, 16'hE000, 16'hE000};
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU | REGWE | PCLD | DONE},
            {SF, F1}, {SD, NONE}, {SE, ALU | PCLD | PCSRC | DONE}, {SF, F1}};
    for (int i = 0; i < 7; i++) begin
      instr = ins[i];
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL jal_jr cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [13:0] exp [7];
    logic [15:0] ins [7];
    start(16'h2000);
    mem_ack = 1'b1;
    ins = '{16'h2000, 16'h2000, 16'h2000, 16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF};
    exp = '{{SF, F1}, {SD, NONE}, {SE, ILL | DONE},
            {SF, F1}, {SD, NONE}, {SE, ILL | DONE}, {SF, F1}};
    for (int i = 0; i < 7; i++) begin
      instr = ins[i];
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL illegal cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_run_drop();
    logic [13:0] exp [7];
    start(16'h4001);
    mem_ack = 1'b1;
    exp = '{{SF, F1}, {SD, NONE}, {SE, ALU}, {SM, REQ | ASEL}, {SW, REGWE | DONE},
            {SI, NONE}, {SI, NONE}};
    for (int i = 0; i < 7; i++) begin
      if (i == 1) run = 1'b0;
      #1;
      checks++;
      if (pk() !== exp[i]) begin
        $display("FAIL run_drop cyc%0d got=%h exp=%h", i, pk(), exp[i]); failures++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lcg();
    test_load_wait();
    test_store();
    test_jeq_jlt();
    test_jal_jr();
    test_illegal();
    test_run_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
